// File: rtl/wave_pkg.sv
// -----------------------------------------------------------------------------
// wave_pkg
// Shared definitions for the wave capture block: capture FSM states, frame
// geometry and the signed-to-offset-binary sample conversion.
// No ports (package).
// -----------------------------------------------------------------------------
package wave_pkg;

  // Samples per captured frame; the RAM index is 8 bits wide.
  localparam int NUM_SAMPLES = 256;
  localparam int INDEX_W     = 8;
  localparam int ADDR_W      = INDEX_W + 1;
  localparam int CODE_W      = 8;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_e;

  // Takes the top 8 bits of a two's-complement sample. Flipping the sign bit
  // turns it into offset binary: full-scale negative -> 0x00, zero -> 0x80.
  function automatic logic [CODE_W-1:0] to_offset_binary(input logic [CODE_W-1:0] top_bits);
    return {~top_bits[CODE_W-1], top_bits[CODE_W-2:0]};
  endfunction

endpackage

// File: rtl/zero_cross_detect.sv
// -----------------------------------------------------------------------------
// zero_cross_detect
// Keeps the previously accepted sample and flags a positive-going zero
// crossing: the previous sample was negative and the current one is >= 0.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous, active-low reset (prev sample cleared to 0)
//   sample_valid : strobe marking sample_in valid; prev sample updates on it
//   sample_in    : signed sample
//   crossing     : combinational pulse, high on a strobe that crosses upward
// -----------------------------------------------------------------------------
module zero_cross_detect #(
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  output logic                       crossing
);

  logic signed [SAMPLE_W-1:0] prev_sample_d;
  logic signed [SAMPLE_W-1:0] prev_sample_q;

  // The previous sample tracks every strobe, whatever the capture state is.
  always_comb begin
    prev_sample_d = prev_sample_q;
    if (sample_valid) begin
      prev_sample_d = sample_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_sample_q <= '0;
    end else begin
      prev_sample_q <= prev_sample_d;
    end
  end

  assign crossing = sample_valid && (prev_sample_q < 0) && (sample_in >= 0);

endmodule

// File: rtl/wave_capture.sv
// -----------------------------------------------------------------------------
// wave_capture
// Captures one frame of NUM_SAMPLES audio samples, starting at a positive
// zero crossing, into one half of a double-buffered 512-entry sample RAM.
// The display reads the other half; after a frame completes the block waits
// for the display to be idle, swaps halves and re-arms.
//
// Ports
//   clk               : clock, rising edge
//   reset             : asynchronous, active-low reset
//   new_sample_ready  : one-cycle strobe, new_sample_in valid
//   new_sample_in     : signed two's-complement sample
//   wave_display_idle : display is outside the visible wave region
//   write_address     : {write half, sample index} into the sample RAM
//   write_enable      : one-cycle RAM write strobe
//   write_sample      : offset-binary 8-bit sample
//   read_index        : RAM half the display reads (capture writes the other)
//
// Build option
//   WAVE_CAPTURE_DECIMATE_EN : when defined, after the trigger only every
//   second strobe is written, starting with the first one after the trigger.
// -----------------------------------------------------------------------------
module wave_capture #(
  parameter int SAMPLE_W    = 16,
  parameter int NUM_SAMPLES = wave_pkg::NUM_SAMPLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [8:0]          write_address,
  output logic                write_enable,
  output logic [7:0]          write_sample,
  output logic                read_index
);

  import wave_pkg::*;

  localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(NUM_SAMPLES - 1);

  state_e               state_d, state_q;
  logic [INDEX_W-1:0]   count_d, count_q;
  logic                 read_index_d, read_index_q;
  logic                 write_enable_d, write_enable_q;
  logic [ADDR_W-1:0]    write_address_d, write_address_q;
  logic [CODE_W-1:0]    write_sample_d, write_sample_q;
  logic                 crossing;
  logic                 active_write;
  logic [CODE_W-1:0]    sample_code;

  zero_cross_detect #(
    .SAMPLE_W (SAMPLE_W)
  ) u_zero_cross_detect (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (new_sample_ready),
    .sample_in    (new_sample_in),
    .crossing     (crossing)
  );

  assign sample_code = to_offset_binary(new_sample_in[SAMPLE_W-1 -: CODE_W]);

`ifdef WAVE_CAPTURE_DECIMATE_EN
  // take_q high means the next ACTIVE strobe is written; it alternates on
  // every ACTIVE strobe and is primed by the trigger.
  logic take_d, take_q;

  assign active_write = new_sample_ready && take_q;

  always_comb begin
    take_d = take_q;
    if (state_q == ARMED && crossing) begin
      take_d = 1'b1;
    end else if (state_q == ACTIVE && new_sample_ready) begin
      take_d = ~take_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      take_q <= 1'b0;
    end else begin
      take_q <= take_d;
    end
  end
`else
  assign active_write = new_sample_ready;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. The frame ends on the same edge that writes the last index.
  // A crossing seen while WAIT exits is ignored because only ARMED triggers.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED: begin
        if (crossing) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (active_write && count_q == LAST_INDEX) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wave_display_idle) begin
          state_d = ARMED;
        end
      end
      default: state_d = ARMED;
    endcase
  end

  // Datapath and outputs. Address and sample hold their last value between
  // writes; only write_enable returns to zero.
  always_comb begin
    count_d         = count_q;
    read_index_d    = read_index_q;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    write_sample_d  = write_sample_q;
    case (state_q)
      ARMED: begin
        if (crossing) begin
          write_enable_d  = 1'b1;
          write_address_d = {~read_index_q, {INDEX_W{1'b0}}};
          write_sample_d  = sample_code;
          count_d         = INDEX_W'(1);
        end
      end
      ACTIVE: begin
        if (active_write) begin
          write_enable_d  = 1'b1;
          write_address_d = {~read_index_q, count_q};
          write_sample_d  = sample_code;
          count_d         = count_q + INDEX_W'(1);
        end
      end
      WAIT: begin
        if (wave_display_idle) begin
          read_index_d = ~read_index_q;
        end
      end
      default: begin
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q         <= '0;
      read_index_q    <= 1'b0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_sample_q  <= '0;
    end else begin
      count_q         <= count_d;
      read_index_q    <= read_index_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_sample_q  <= write_sample_d;
    end
  end

  assign write_enable  = write_enable_q;
  assign write_address = write_address_q;
  assign write_sample  = write_sample_q;
  assign read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// -----------------------------------------------------------------------------
// tb_wave_capture
// Self-checking bench for wave_capture. A behavioural model pushes the
// expected RAM writes into a queue as each strobe is driven; a monitor pops
// and compares them as the DUT writes. Build with WAVE_CAPTURE_DECIMATE_EN
// defined to exercise the decimating variant.
// -----------------------------------------------------------------------------
module tb_wave_capture;

  import wave_pkg::*;

  localparam int SAMPLE_W = 16;
`ifdef WAVE_CAPTURE_DECIMATE_EN
  localparam int FRAME_STROBES = 510;
  localparam bit DECIMATE      = 1'b1;
`else
  localparam int FRAME_STROBES = 255;
  localparam bit DECIMATE      = 1'b0;
`endif

  logic                clk;
  logic                reset;
  logic                new_sample_ready;
  logic [SAMPLE_W-1:0] new_sample_in;
  logic                wave_display_idle;
  logic [8:0]          write_address;
  logic                write_enable;
  logic [7:0]          write_sample;
  logic                read_index;

  int checks;
  int errors;
  int write_count;
  int exp_writes;

  logic [16:0] exp_q[$];
  logic [16:0] mon_e;

  state_e             m_state;
  logic [7:0]         m_count;
  logic               m_ri;
  logic signed [15:0] m_prev;
  logic               m_take;

  wave_capture #(
    .SAMPLE_W    (SAMPLE_W),
    .NUM_SAMPLES (256)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offset-binary code computed arithmetically: shift the range up by 2^15.
  function automatic logic [7:0] expectedCode(input logic signed [15:0] s);
    int v;
    v = s;
    v = (v + 32768) >> 8;
    return v[7:0];
  endfunction

  task automatic pushWrite(input logic [7:0] idx, input logic signed [15:0] s);
    exp_q.push_back({~m_ri, idx, expectedCode(s)});
    exp_writes++;
  endtask

  task automatic modelReset();
    m_state = ARMED;
    m_count = 8'd0;
    m_ri    = 1'b0;
    m_prev  = 16'sd0;
    m_take  = 1'b0;
    exp_q.delete();
  endtask

  task automatic applyStimulus(input logic signed [15:0] s, input logic idle_in);
    @(negedge clk);
    new_sample_ready  = 1'b1;
    new_sample_in     = s;
    wave_display_idle = idle_in;
    case (m_state)
      ARMED: begin
        if (m_prev < 0 && s >= 0) begin
          pushWrite(8'd0, s);
          m_count = 8'd1;
          m_take  = 1'b1;
          m_state = ACTIVE;
        end
      end
      ACTIVE: begin
        if (DECIMATE && !m_take) begin
          m_take = 1'b1;
        end else begin
          pushWrite(m_count, s);
          m_take = 1'b0;
          if (m_count == 8'd255) begin
            m_state = WAIT;
          end
          m_count = m_count + 8'd1;
        end
      end
      WAIT: begin
        if (idle_in) begin
          m_ri    = ~m_ri;
          m_state = ARMED;
        end
      end
      default: m_state = ARMED;
    endcase
    m_prev = s;
    @(negedge clk);
    new_sample_ready  = 1'b0;
    wave_display_idle = 1'b0;
  endtask

  task automatic pulseIdle();
    @(negedge clk);
    wave_display_idle = 1'b1;
    if (m_state == WAIT) begin
      m_ri    = ~m_ri;
      m_state = ARMED;
    end
    @(negedge clk);
    wave_display_idle = 1'b0;
  endtask

  task automatic checkPhase(input string tag);
    repeat (2) @(negedge clk);
    checkOutput({tag, "_drained"}, exp_q.size(), 0);
    checkOutput({tag, "_writes"}, write_count, exp_writes);
    checkOutput({tag, "_state"}, 32'(dut.state_q), 32'(m_state));
    checkOutput({tag, "_read_index"}, 32'(read_index), 32'(m_ri));
  endtask

  task automatic feedFrame();
    logic signed [15:0] s;
    for (int i = 0; i < FRAME_STROBES; i++) begin
      if (i == 10)      s = -16'sd32768;
      else if (i == 11) s = 16'sd32767;
      else              s = 16'(i * 1237 - 20000);
      applyStimulus(s, 1'b0);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset && write_enable) begin
      write_count++;
      checkOutput("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(write_address), 32'(mon_e[16:8]));
        checkOutput("wr_data", 32'(write_sample), 32'(mon_e[7:0]));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks            = 0;
    errors            = 0;
    write_count       = 0;
    exp_writes        = 0;
    reset             = 1'b0;
    new_sample_ready  = 1'b0;
    new_sample_in     = '0;
    wave_display_idle = 1'b0;
    modelReset();

    repeat (2) @(negedge clk);
    checkOutput("rst_we", 32'(write_enable), 32'd0);
    checkOutput("rst_addr", 32'(write_address), 32'd0);
    checkOutput("rst_data", 32'(write_sample), 32'd0);
    checkOutput("rst_read_index", 32'(read_index), 32'd0);
    checkOutput("rst_state", 32'(dut.state_q), 32'(ARMED));
    reset = 1'b1;

    $display("[TB] first trigger -5, +3");
    applyStimulus(-16'sd5, 1'b0);
    applyStimulus(16'sd3, 1'b0);
    checkPhase("trigger1");

    $display("[TB] rest of frame, then strobes in WAIT");
    feedFrame();
    checkPhase("frame1");
    applyStimulus(-16'sd3, 1'b0);
    applyStimulus(16'sd3, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(16'(i * 999 - 9000), 1'b0);
    checkPhase("wait1");

    $display("[TB] idle pulse swaps halves");
    pulseIdle();
    checkPhase("swap1");
    applyStimulus(-16'sd7, 1'b0);
    applyStimulus(16'sd7, 1'b0);
    checkPhase("trigger2");
    feedFrame();
    checkPhase("frame2");

    $display("[TB] crossing on the WAIT exit cycle must not trigger");
    applyStimulus(-16'sd5, 1'b0);
    applyStimulus(16'sd5, 1'b1);
    applyStimulus(16'sd6, 1'b0);
    checkPhase("wait_exit");

    $display("[TB] +10 +20 -1 then 0");
    applyStimulus(16'sd10, 1'b0);
    applyStimulus(16'sd20, 1'b0);
    applyStimulus(-16'sd1, 1'b0);
    checkPhase("no_trigger");
    applyStimulus(16'sd0, 1'b0);
    checkPhase("trigger3");

    $display("[TB] reset mid-capture");
    for (int i = 0; i < 99; i++) applyStimulus(16'(i * 311 + 5), 1'b0);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst_we", 32'(write_enable), 32'd0);
    checkOutput("midrst_addr", 32'(write_address), 32'd0);
    checkOutput("midrst_data", 32'(write_sample), 32'd0);
    checkOutput("midrst_read_index", 32'(read_index), 32'd0);
    checkOutput("midrst_state", 32'(dut.state_q), 32'(ARMED));
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(16'sd0, 1'b0);
    applyStimulus(-16'sd1, 1'b0);
    applyStimulus(16'sd0, 1'b0);
    checkPhase("trigger4");
    feedFrame();
    checkPhase("frame4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, width of the incoming signed audio sample.
REQ-002 SHALL have parameter NUM_SAMPLES, default 256, samples captured per frame; fixed to a power of two matching 8 low address bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port new_sample_ready  input  1  one-cycle strobe marking new_sample_in valid.
REQ-006 SHALL have port new_sample_in  input  SAMPLE_W  signed two's-complement audio sample.
REQ-007 SHALL have port wave_display_idle  input  1  high while the display is outside the visible wave region.
REQ-008 SHALL have port write_address  output  9  {write half, sample index[7:0]} into the 512-entry sample RAM.
REQ-009 SHALL have port write_enable  output  1  one-cycle RAM write strobe.
REQ-010 SHALL have port write_sample  output  8  unsigned offset-binary sample written to RAM.
REQ-011 SHALL have port read_index  output  1  RAM half the display reads; the capture writes half ~read_index.

Function
REQ-012 SHALL implement states ARMED, ACTIVE, WAIT.
REQ-013 SHALL register prev_sample on every new_sample_ready in all states.
REQ-014 In ARMED, SHALL detect a positive zero crossing: prev_sample negative and new_sample_in non-negative, on a new_sample_ready cycle.
REQ-015 On a crossing, SHALL write the triggering sample at index 0, set count to 1, and enter ACTIVE.
REQ-016 In ACTIVE, SHALL write each new_sample_ready sample at index count, then increment count.
REQ-017 SHALL enter WAIT on the same edge that writes index NUM_SAMPLES-1; count wraps to 0.
REQ-018 In WAIT, SHALL ignore samples for writing; when wave_display_idle=1, SHALL toggle read_index and enter ARMED.
REQ-019 SHALL ignore wave_display_idle in ARMED and ACTIVE.
REQ-020 write_sample SHALL equal {~s[SAMPLE_W-1], s[SAMPLE_W-2:SAMPLE_W-8]}; negative full-scale maps to 0x00, zero to 0x80.
REQ-021 All outputs SHALL be registered; write_enable, write_address and write_sample SHALL be valid the cycle after the accepted new_sample_ready.
REQ-022 write_address[8] SHALL equal ~read_index at every write.
REQ-023 A new_sample_ready in the cycle WAIT exits SHALL update prev_sample but SHALL NOT trigger.

Reset
REQ-024 While reset=0, state SHALL be ARMED, count=0, prev_sample=0, read_index=0, write_enable=0, write_address=0, write_sample=0.
REQ-025 Reset mid-capture SHALL abandon the partial frame; the next frame restarts at index 0 in half 1.

Configuration
REQ-026 With WAVE_CAPTURE_DECIMATE_EN defined, ACTIVE SHALL write only every second new_sample_ready, starting with the one after the trigger; the trigger still writes index 0.
REQ-027 Without WAVE_CAPTURE_DECIMATE_EN, every ACTIVE new_sample_ready SHALL be written; no decimation logic SHALL be present.

Structure
REQ-028 Package wave_pkg SHALL hold the state enum, NUM_SAMPLES, and the offset-binary conversion function.
REQ-029 Sub-module zero_cross_detect SHALL hold prev_sample and produce the crossing pulse.

Verification
REQ-030 After reset, feed samples -5, +3 with strobes -> write_enable pulses once, write_address=0x100, write_sample=0x80, state ACTIVE.
REQ-031 After the trigger, feed 255 more strobes -> writes cover 0x101..0x1FF; enters WAIT after 0x1FF; no further writes.
REQ-032 In WAIT, pulse wave_display_idle -> read_index becomes 1; the next crossing writes at 0x000.
REQ-033 In ARMED, feed +10, +20, -1 -> no writes; then feed 0 -> trigger, write_sample=0x80.
REQ-034 Assert reset at count=100 -> outputs 0 and state ARMED within the same cycle; a later capture starts at 0x100.
REQ-035 With WAVE_CAPTURE_DECIMATE_EN, feed the trigger plus 510 strobes -> exactly 256 writes, then WAIT.
